lsu_subword: RTL and testbench
==============================

# lsu_subword

Load/store unit sitting between the single-cycle core's execute stage and the word-only data memory (256 x 32, word-indexed by addr[9:2], combinational read gated by MemRead, synchronous word write on MemWrite). It converts byte/halfword/word loads and stores into word accesses: it sign- or zero-extends load data, and performs read-modify-write for sb/sh. It also flags misaligned or illegal accesses without touching memory. It exposes a valid/ready request and a one-cycle response pulse, so the core stalls while an access is in flight.

## Interface
- No parameters; data path fixed at 32 bits, little-endian.
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  core presents a request
- req_ready  out  1  high only in IDLE; accept = req_valid & req_ready at a rising edge
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low byte/half used for sb/sh)
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_valid: misaligned or illegal funct3
- resp_rdata  out  32  extended load data; 0 for stores and errors; held until next response
- mem_read  out  1  to DMEM MemRead
- mem_write  out  1  to DMEM MemWrite
- mem_addr  out  32  {latched addr[31:2], 2'b00}
- mem_wdata  out  32  word to write; 0 when mem_write low
- mem_rdata  in  32  DMEM ReadData (combinational)

## Operation
- States: IDLE, LOAD, STORE_W, RMW_RD, RMW_WR, DONE.
- IDLE: on accept, latch we/funct3/addr/wdata, then branch:
  - illegal (load funct3 011/110/111; store funct3 not 000/001/010) or misaligned (h/hu with addr[0]=1; w with addr[1:0]!=0) -> DONE with err=1, no memory access.
  - load -> LOAD; sw -> STORE_W; sb/sh -> RMW_RD.
- LOAD: mem_read=1; lane k=addr[1:0]. lb/lbu pick byte k; lh/lhu pick half addr[1]. Sign-extend (b, h) or zero-extend (bu, hu); w passes through. Register into resp_rdata. -> DONE.
- STORE_W: mem_write=1, mem_wdata=latched wdata. -> DONE.
- RMW_RD: mem_read=1; capture mem_rdata into merge register. -> RMW_WR.
- RMW_WR: mem_write=1; mem_wdata = merge word with byte k replaced by wdata[7:0] (sb) or half addr[1] replaced by wdata[15:0] (sh); other lanes unchanged. -> DONE.
- DONE: resp_valid=1, resp_err as latched; -> IDLE.
- mem_read/mem_write are pure decodes of state; both 0 in IDLE and DONE. mem_write is gated by rst_n, so no write is issued in any cycle where rst_n=0.
- Stores set resp_rdata to 0.

## Timing
- Reset (rst_n=0 at edge): state IDLE, resp_valid 0, resp_err 0, resp_rdata 0, merge register 0, req_ready 1 after the edge. Reset in any state abandons the access; a partially completed RMW leaves memory unmodified.
- Latency from accept edge to resp_valid high:
  - misaligned/illegal: 1 cycle
  - load or sw: 2 cycles
  - sb/sh: 3 cycles
- req_ready is 0 from the cycle after accept until the cycle after DONE. Issue rate is one request per latency+1 cycles; no overlap.
- req_* signals are ignored outside IDLE. Requests are not buffered, and the core must hold req_valid until accepted.
- resp_valid is never high for two consecutive cycles.

## Test plan
- mem[1]=0x8899AABB; lb addr 0x5 -> resp_rdata 0xFFFFFFAA after 2 cycles; lbu addr 0x7 -> 0x00000088; lh addr 0x6 -> 0xFFFF8899; lhu addr 0x4 -> 0x0000AABB.
- mem[2]=0x11223344; sb addr 0x9, wdata 0xDEADBEEF -> RMW_RD then RMW_WR writes 0x1122EF44, resp 3 cycles after accept; following lw addr 0x8 -> 0x1122EF44.
- sh addr 0xA, wdata 0x0000CAFE over mem[2]=0x11223344 -> 0xCAFE3344; sw addr 0xC data 0x12345678 -> mem[3]=0x12345678, resp 2 cycles.
- lw addr 0x2, sh addr 0x3, load funct3 011 -> resp_err=1 1 cycle after accept, mem_read and mem_write stay 0 throughout, resp_rdata 0.
- sb issued, rst_n=0 during the RMW_WR cycle -> mem_write low, memory word unchanged, resp_valid never pulses, req_ready=1 after reset released.
- Back-to-back: req_valid held high with lw, lw -> second accepted only in the cycle after the first DONE; req_ready low in between; resp_valid single-cycle pulses.

Source files
------------

// File: rtl/lsu_subword.sv
// Sub-word load/store unit in front of a word-only data memory.
// Handles lb/lh/lw/lbu/lhu with extension, sb/sh via read-modify-write, and flags bad accesses.
module lsu_subword (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STORE_W, S_RMW_RD, S_RMW_WR, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_bad;

  function automatic logic access_bad(input logic we, input logic [2:0] f3,
                                      input logic [1:0] a);
    logic illegal;
    logic misal;
    if (we) illegal = !(f3 inside {3'b000, 3'b001, 3'b010});
    else    illegal = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misal = ((f3[1:0] == 2'b01) && a[0]) || ((f3 == 3'b010) && (a != 2'b00));
    return illegal || misal;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b100:  res = {24'h0, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b101:  res = {16'h0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] word, input logic [31:0] wd);
    logic [31:0] res;
    res = word;
    if (f3 == 3'b000) res[{a, 3'b000} +: 8] = wd[7:0];
    else              res[{a[1], 4'b0000} +: 16] = wd[15:0];
    return res;
  endfunction

  assign req_bad = access_bad(req_we, req_funct3, req_addr[1:0]);

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = req_bad;
          if (req_bad) begin
            rdata_d = 32'h0;
            state_d = S_DONE;
          end else if (!req_we)            state_d = S_LOAD;
          else if (req_funct3 == 3'b010) state_d = S_STORE_W;
          else                           state_d = S_RMW_RD;
        end
      end
      S_LOAD: begin
        rdata_d = load_extend(funct3_q, addr_q[1:0], mem_rdata);
        state_d = S_DONE;
      end
      S_STORE_W: begin
        rdata_d = 32'h0;
        state_d = S_DONE;
      end
      S_RMW_RD: begin
        merge_d = mem_rdata;
        state_d = S_RMW_WR;
      end
      S_RMW_WR: begin
        rdata_d = 32'h0;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
    end
  end

  // Request fields only change on accept, so they need no reset.
  always_ff @(posedge clk) begin
    we_q     <= we_d;
    funct3_q <= funct3_d;
    addr_q   <= addr_d;
    wdata_q  <= wdata_d;
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;
  assign mem_read   = (state_q == S_LOAD) || (state_q == S_RMW_RD);
  // Gating by rst_n keeps a reset mid-RMW from committing a half-finished write.
  assign mem_write  = rst_n && ((state_q == S_STORE_W) || (state_q == S_RMW_WR));
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = !mem_write ? 32'h0 :
                      (state_q == S_STORE_W) ? wdata_q :
                      store_merge(funct3_q, addr_q[1:0], merge_q, wdata_q);

endmodule

// File: tb/tb_lsu_subword.sv
// Directed bench for lsu_subword with a behavioural 256x32 word memory.
module tb_lsu_subword;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:255];
  int          checks = 0;
  int          errors = 0;

  lsu_subword dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_read ? mem[mem_addr[9:2]] : 32'h0;
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, input logic exp_err, input logic [31:0] exp_rd);
    int   lat;
    logic saw_mem;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    check({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    step();
    req_valid = 1'b0;
    lat = 1;
    saw_mem = mem_read | mem_write;
    while (!resp_valid && lat < 8) begin
      step();
      lat++;
      saw_mem = saw_mem | mem_read | mem_write;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_err"}, {31'h0, resp_err}, {31'h0, exp_err});
    check({tag, "_rdata"}, resp_rdata, exp_rd);
    if (exp_err) check({tag, "_memacc"}, {31'h0, saw_mem}, 32'h0);
    step();
    check({tag, "_pulse"}, {31'h0, resp_valid}, 32'h0);
    check({tag, "_idle"}, {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[1] = 32'h8899AABB;
    mem[2] = 32'h11223344;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    step(); step();
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_err", {31'h0, resp_err}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_memctl", {30'h0, mem_read, mem_write}, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    step();

    do_req("lb",  1'b0, 3'b000, 32'h5, 32'h0, 2, 1'b0, 32'hFFFFFFAA);
    do_req("lbu", 1'b0, 3'b100, 32'h7, 32'h0, 2, 1'b0, 32'h00000088);
    do_req("lh",  1'b0, 3'b001, 32'h6, 32'h0, 2, 1'b0, 32'hFFFF8899);
    do_req("lhu", 1'b0, 3'b101, 32'h4, 32'h0, 2, 1'b0, 32'h0000AABB);

    do_req("sb",  1'b1, 3'b000, 32'h9, 32'hDEADBEEF, 3, 1'b0, 32'h0);
    check("sb_mem", mem[2], 32'h1122EF44);
    do_req("lw_after_sb", 1'b0, 3'b010, 32'h8, 32'h0, 2, 1'b0, 32'h1122EF44);

    mem[2] = 32'h11223344;
    do_req("sh",  1'b1, 3'b001, 32'hA, 32'h0000CAFE, 3, 1'b0, 32'h0);
    check("sh_mem", mem[2], 32'hCAFE3344);
    do_req("sw",  1'b1, 3'b010, 32'hC, 32'h12345678, 2, 1'b0, 32'h0);
    check("sw_mem", mem[3], 32'h12345678);
    do_req("lw_c", 1'b0, 3'b010, 32'hC, 32'h0, 2, 1'b0, 32'h12345678);

    do_req("lw_mis",  1'b0, 3'b010, 32'h2, 32'h0, 1, 1'b1, 32'h0);
    do_req("sh_mis",  1'b1, 3'b001, 32'h3, 32'hFFFF, 1, 1'b1, 32'h0);
    do_req("ld_f011", 1'b0, 3'b011, 32'h0, 32'h0, 1, 1'b1, 32'h0);
    do_req("st_f100", 1'b1, 3'b100, 32'h4, 32'h0, 1, 1'b1, 32'h0);
    check("err_nowrite", mem[3], 32'h12345678);

    // Reset lands while the RMW write is being presented.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h4;
    req_wdata = 32'h00000055;
    step();
    req_valid = 1'b0;
    check("rmw_rd_read", {31'h0, mem_read}, 32'h1);
    step();
    check("rmw_wr_write", {31'h0, mem_write}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rmw_rst_gate", {31'h0, mem_write}, 32'h0);
    check("rmw_rst_wdata", mem_wdata, 32'h0);
    step();
    rst_n = 1'b1;
    #1;
    check("rmw_rst_ready", {31'h0, req_ready}, 32'h1);
    check("rmw_rst_valid", {31'h0, resp_valid}, 32'h0);
    check("rmw_rst_mem", mem[1], 32'h8899AABB);
    step();
    check("rmw_rst_valid2", {31'h0, resp_valid}, 32'h0);
    check("rmw_rst_mem2", mem[1], 32'h8899AABB);

    // Back-to-back loads with req_valid held high.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8;
    step();
    req_addr = 32'hC;
    check("b2b_load1_ready", {31'h0, req_ready}, 32'h0);
    check("b2b_load1_valid", {31'h0, resp_valid}, 32'h0);
    step();
    check("b2b_done1_valid", {31'h0, resp_valid}, 32'h1);
    check("b2b_done1_rdata", resp_rdata, 32'hCAFE3344);
    check("b2b_done1_ready", {31'h0, req_ready}, 32'h0);
    step();
    check("b2b_idle_valid", {31'h0, resp_valid}, 32'h0);
    check("b2b_idle_ready", {31'h0, req_ready}, 32'h1);
    step();
    check("b2b_load2_ready", {31'h0, req_ready}, 32'h0);
    check("b2b_load2_valid", {31'h0, resp_valid}, 32'h0);
    step();
    req_valid = 1'b0;
    check("b2b_done2_valid", {31'h0, resp_valid}, 32'h1);
    check("b2b_done2_rdata", resp_rdata, 32'h12345678);
    step();
    check("b2b_end_valid", {31'h0, resp_valid}, 32'h0);
    check("b2b_end_ready", {31'h0, req_ready}, 32'h1);
    check("b2b_rdata_hold", resp_rdata, 32'h12345678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
